spi_mnrch_gen: RTL

Parametrised SPI monarch (mode 0, MSB-first) serving the A2D, inertial and other serial peripherals in the design. It generalises the fixed 16-bit monarch: configurable frame width and SCLK divider, a per-transaction bit length, and a `hold` option that keeps SS_n asserted across consecutive words for multi-word frames. It sits between a requesting controller (`snd`/`cmd` → `done`/`resp`) and the four SPI pins.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sclk_gen.sv | 37 +++
 rtl/spi_mnrch_gen.sv | 83 ++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and divider constants for the SPI monarch
package spi_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, BACK, HOLD} spi_state_t;

   typedef enum logic [1:0] {DV_LOAD, DV_SHFT, DV_FULL} div_sel_t;

   // LOAD places the first SCLK fall 2^(DIV_BITS-2)+1 clks after the start edge
   function automatic int div_val(input int div_bits, input div_sel_t sel);
      return sel == DV_LOAD ? (1 << div_bits) - (1 << (div_bits - 2)) - 1 :
             sel == DV_SHFT ? (1 << (div_bits - 1)) + 1 : (1 << div_bits) - 1;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SCLK divider with load, shift strobe and end-of-period flag
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int DIV_BITS = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic ld,
   output logic sclk,
   output logic shft,
   output logic full
);

   localparam logic [DIV_BITS-1:0] LOAD = DIV_BITS'(div_val(DIV_BITS, DV_LOAD));
   localparam logic [DIV_BITS-1:0] SHFT = DIV_BITS'(div_val(DIV_BITS, DV_SHFT));
   localparam logic [DIV_BITS-1:0] FULL = DIV_BITS'(div_val(DIV_BITS, DV_FULL));

   logic [DIV_BITS-1:0] div;
   logic                armed;

   // divider free-runs unless loaded; armed waits for the first wrap because the
   // shift value equals LOAD when DIV_BITS is 3
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         div   <= LOAD;
         armed <= 1'b0;
      end else begin
         div   <= ld ? LOAD : div + 1'b1;
         armed <= !ld && (armed || full);
      end

   assign sclk = div[DIV_BITS-1];
   assign full = div == FULL;
   assign shft = armed && div == SHFT;

endmodule

// File: rtl/spi_mnrch_gen.sv
// spi_mnrch_gen: parametrised mode-0 MSB-first SPI monarch with frame hold
module spi_mnrch_gen
   import spi_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DIV_BITS = 5,
   parameter int LEN_W    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             snd,
   input  logic [WIDTH-1:0] cmd,
   input  logic [LEN_W-1:0] len,
   input  logic             hold,
   input  logic             MISO,
   output logic             SS_n,
   output logic             SCLK,
   output logic             MOSI,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] resp
);

   spi_state_t       state, nxt;
   logic [LEN_W-1:0] cnt, len_q, len_eff;
   logic [WIDTH-1:0] shreg;
   logic             hold_q, shft, full, ld, accept, set_done;

   assign len_eff  = (len == '0 || len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
   assign accept   = snd && (state == IDLE || state == HOLD);
   assign set_done = state == BACK && full;
   assign ld       = state == IDLE || state == HOLD || set_done;
   assign busy     = state == SHIFT || state == BACK;
   assign MOSI     = shreg[WIDTH-1];
   assign resp     = shreg;

   spi_sclk_gen #(.DIV_BITS(DIV_BITS)) u_sclk (
      .clk  (clk),
      .rst  (rst),
      .ld   (ld),
      .sclk (SCLK),
      .shft (shft),
      .full (full)
   );

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= nxt;

   // next state: leave SHIFT on the last shift so BACK always sees the next full
   always_comb begin
      nxt = state;
      if (accept)                                              nxt = SHIFT;
      else if (state == SHIFT && shft && cnt + 1'b1 == len_q) nxt = BACK;
      else if (set_done)                                       nxt = hold_q ? HOLD : IDLE;
   end

   // transaction registers: pre-shift cmd on accept so resp ends right-aligned
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         SS_n   <= 1'b1;
         done   <= 1'b0;
         cnt    <= '0;
         shreg  <= '0;
         len_q  <= '0;
         hold_q <= 1'b0;
      end else if (accept) begin
         SS_n   <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
         shreg  <= cmd << (LEN_W'(WIDTH) - len_eff);
         len_q  <= len_eff;
         hold_q <= hold;
      end else if (state == SHIFT && shft) begin
         shreg  <= {shreg[WIDTH-2:0], MISO};
         cnt    <= cnt + 1'b1;
      end else if (set_done) begin
         done   <= 1'b1;
         SS_n   <= !hold_q;
      end

endmodule
